event_encoder: RTL and testbench
================================

EVENT_ENCODER -- requirements
Module: event_encoder

Interface
REQ-001 The parameter RR_EN SHALL default to 1 and select round-robin arbitration when 1, or fixed priority (index 7 highest) when 0.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous reset, active-low.
REQ-004 req  input  8  event request lines; a 0->1 transition on req[i] is one event on line i.
REQ-005 code  output  3  binary index of the granted event line, valid while valid=1.
REQ-006 valid  output  1  code holds a presented event.
REQ-007 ready  input  1  consumer accepts the presented code when valid=1 and ready=1 at a rising clk edge.
REQ-008 pending  output  8  registered set of captured, not-yet-accepted events.
REQ-009 overflow  output  1  one-cycle pulse: an event arrived on a line already pending.

Function
REQ-010 The block SHALL register req into req_q every clk edge; an event on line i is detected at an edge where req[i]=1 and req_q[i]=0.
REQ-011 A detected event SHALL set pending[i] at the same edge, visible on pending the following cycle.
REQ-012 The block SHALL implement two states: IDLE (valid=0) and PRESENT (valid=1).
REQ-013 In IDLE with pending!=0, the block SHALL load code with the selected index, set valid=1, and enter PRESENT at that edge; with pending=0 it SHALL stay in IDLE.
REQ-014 With RR_EN=1, the selected index SHALL be the first set pending bit at or above pointer ptr, searching upward and wrapping 7->0.
REQ-015 With RR_EN=0, the selected index SHALL be the highest-numbered set pending bit; ptr is unused.
REQ-016 In PRESENT, code and valid SHALL remain stable until acceptance, regardless of new events or pending changes.
REQ-017 On acceptance, the block SHALL clear pending[code], set ptr to code+1 modulo 8, and return to IDLE, so valid is 0 for at least one cycle between grants (maximum one grant per 2 cycles).
REQ-018 If an event on line code coincides with its acceptance edge, pending[code] SHALL remain set (new event retained) and overflow SHALL NOT pulse.
REQ-019 If an event is detected on line i while pending[i]=1 and i is not being cleared at that edge, pending[i] SHALL stay 1 and overflow SHALL be 1 for exactly the next cycle.
REQ-020 Multiple events on different lines at the same edge SHALL all be captured.
REQ-021 ready while valid=0 SHALL have no effect.
REQ-022 The detected-event-to-valid latency SHALL be 2 cycles when the block is IDLE and no other line is pending.

Reset
REQ-023 rst_n=0 SHALL immediately force valid=0, code=0, pending=0, overflow=0, ptr=0, state IDLE, and req_q=8'hFF.
REQ-024 Because req_q resets to 8'hFF, a req line held high through reset release SHALL NOT generate an event until it falls and rises again.
REQ-025 Reset asserted while in PRESENT SHALL discard the presented and all pending events without an acceptance.

Verification
REQ-026 Single event: ready=1, pulse req[5] for 1 cycle -> valid=1 with code=5 two cycles later, held 1 cycle; pending returns to 0.
REQ-027 Round-robin: RR_EN=1, ready=0, raise req[1], req[3], and req[6] together; then ready=1 -> codes 1, 3, 6 in order, each grant separated by a valid=0 cycle.
REQ-028 Fixed priority: RR_EN=0, same stimulus -> codes 6, 3, 1.
REQ-029 Backpressure and overflow: ready=0, toggle req[2] 0->1->0->1 -> code=2 is held stable, overflow pulses once on the second rise, and a single grant results after ready=1.
REQ-030 Coincident re-event: with code=4 presented, the req[4] rise lands on the acceptance edge -> no overflow, pending[4]=1 after acceptance, and code=4 is presented again.
REQ-031 Reset: assert rst_n=0 mid-PRESENT with req[0] held high, then release -> valid=0 and pending=0 immediately, and there is no event until req[0] falls and rises.

Source files
------------

// File: rtl/event_encoder.sv
// rtl/event_encoder.sv - edge-detecting 8-line event encoder with round-robin or fixed-priority grant
//
// Purpose:
//   Captures rising edges on eight request lines into a pending set and presents
//   one pending line at a time as a binary code using a valid/ready handshake.
//   After each accepted grant the block returns to IDLE for at least one cycle.
//
// Parameters:
//   RR_EN    1 = round-robin starting at ptr; 0 = fixed priority with index 7 highest
//
// Ports:
//   clk      rising-edge clock for all state
//   rst_n    asynchronous active-low reset
//   req      [7:0] event request lines; a 0->1 transition is one event
//   code     [2:0] index of the presented line, valid while valid=1
//   valid    code holds a presented event
//   ready    consumer accepts code on a clock edge where valid=1 and ready=1
//   pending  [7:0] captured events that have not been accepted yet
//   overflow one-cycle pulse: an event arrived on a line that was already pending

module event_encoder #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [2:0] code,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] req_q;
  logic [2:0] ptr;
  logic [7:0] evt;
  logic [7:0] clr_mask;
  logic [7:0] pending_nxt;
  logic       overflow_nxt;
  logic       accept;
  logic       load;
  logic [2:0] sel_idx;

  // Rising-edge detect. req_q resets high so a line held high through reset
  // must fall and rise again before it counts as an event.
  assign evt = req & ~req_q;

  // The accepted line is cleared first and new events are OR-ed in afterwards,
  // so an event coinciding with acceptance of its own line is retained and
  // does not count as an overflow.
  assign clr_mask     = accept ? (8'b1 << code) : 8'b0;
  assign pending_nxt  = (pending & ~clr_mask) | evt;
  assign overflow_nxt = |(evt & pending & ~clr_mask);

  // Line selection from the registered pending set.
  always_comb begin
    sel_idx = 3'd0;
    if (RR_EN) begin
      // Walk from farthest to nearest offset so the nearest set bit at or
      // above ptr (wrapping 7->0) is the last assignment and wins.
      for (int k = 7; k >= 0; k--) begin
        if (pending[ptr + 3'(k)]) begin
          sel_idx = ptr + 3'(k);
        end
      end
    end else begin
      // Ascending scan: the highest set bit is the last assignment.
      for (int k = 0; k < 8; k++) begin
        if (pending[k]) begin
          sel_idx = 3'(k);
        end
      end
    end
  end

  // FSM next-state and control.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    valid     = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          load      = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        valid = 1'b1;
        if (ready) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= 8'hFF;
      pending  <= 8'h00;
      overflow <= 1'b0;
      ptr      <= 3'd0;
      code     <= 3'd0;
    end else begin
      req_q    <= req;
      pending  <= pending_nxt;
      overflow <= overflow_nxt;
      if (load) begin
        code <= sel_idx;
      end
      if (accept) begin
        ptr <= code + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_event_encoder.sv
// tb/tb_event_encoder.sv - directed self-checking bench for event_encoder
//
// Two instances share all inputs: u_rr (RR_EN=1) and u_fp (RR_EN=0).
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.

module tb_event_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       ready;

  logic [2:0] code_rr, code_fp;
  logic       valid_rr, valid_fp;
  logic [7:0] pending_rr, pending_fp;
  logic       overflow_rr, overflow_fp;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  event_encoder #(.RR_EN(1'b1)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .code     (code_rr),
    .valid    (valid_rr),
    .ready    (ready),
    .pending  (pending_rr),
    .overflow (overflow_rr)
  );

  event_encoder #(.RR_EN(1'b0)) u_fp (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .code     (code_fp),
    .valid    (valid_fp),
    .ready    (ready),
    .pending  (pending_fp),
    .overflow (overflow_fp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    ready = 1'b0;
    #2;
    checks++; if (valid_rr !== 1'b0) begin fails++; $display("FAIL reset_valid_rr: got %0b want 0", valid_rr); end
    checks++; if (code_rr !== 3'd0) begin fails++; $display("FAIL reset_code_rr: got %0d want 0", code_rr); end
    checks++; if (pending_rr !== 8'h00) begin fails++; $display("FAIL reset_pending_rr: got %h want 00", pending_rr); end
    checks++; if (overflow_rr !== 1'b0) begin fails++; $display("FAIL reset_overflow_rr: got %0b want 0", overflow_rr); end
    checks++; if (valid_fp !== 1'b0) begin fails++; $display("FAIL reset_valid_fp: got %0b want 0", valid_fp); end
    checks++; if (pending_fp !== 8'h00) begin fails++; $display("FAIL reset_pending_fp: got %h want 00", pending_fp); end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if (valid_rr !== 1'b0 || pending_rr !== 8'h00) begin fails++; $display("FAIL post_reset_idle: got valid=%0b pending=%h want 0/00", valid_rr, pending_rr); end
  endtask

  task automatic test_single();
    ready = 1'b1;
    req   = 8'h20;
    tick();
    req = 8'h00;
    checks++; if (pending_rr !== 8'h20) begin fails++; $display("FAIL single_pending: got %h want 20", pending_rr); end
    checks++; if (valid_rr !== 1'b0) begin fails++; $display("FAIL single_valid_early: got %0b want 0", valid_rr); end
    tick();
    checks++; if (valid_rr !== 1'b1) begin fails++; $display("FAIL single_valid: got %0b want 1", valid_rr); end
    checks++; if (code_rr !== 3'd5) begin fails++; $display("FAIL single_code_rr: got %0d want 5", code_rr); end
    checks++; if (code_fp !== 3'd5) begin fails++; $display("FAIL single_code_fp: got %0d want 5", code_fp); end
    tick();
    checks++; if (valid_rr !== 1'b0) begin fails++; $display("FAIL single_valid_drop: got %0b want 0", valid_rr); end
    checks++; if (pending_rr !== 8'h00) begin fails++; $display("FAIL single_pending_clear: got %h want 00", pending_rr); end
    tick();
    checks++; if (valid_rr !== 1'b0) begin fails++; $display("FAIL single_no_regrant: got %0b want 0", valid_rr); end
  endtask

  task automatic test_arbitration();
    do_reset();
    ready = 1'b0;
    req   = 8'h4A;
    tick();
    req = 8'h00;
    checks++; if (pending_rr !== 8'h4A) begin fails++; $display("FAIL arb_pending_all: got %h want 4a", pending_rr); end
    tick();
    checks++; if (valid_rr !== 1'b1 || code_rr !== 3'd1) begin fails++; $display("FAIL rr_grant0: got valid=%0b code=%0d want 1/1", valid_rr, code_rr); end
    checks++; if (valid_fp !== 1'b1 || code_fp !== 3'd6) begin fails++; $display("FAIL fp_grant0: got valid=%0b code=%0d want 1/6", valid_fp, code_fp); end
    tick();
    checks++; if (valid_rr !== 1'b1 || code_rr !== 3'd1) begin fails++; $display("FAIL rr_hold: got valid=%0b code=%0d want 1/1", valid_rr, code_rr); end
    ready = 1'b1;
    tick();
    checks++; if (valid_rr !== 1'b0 || valid_fp !== 1'b0) begin fails++; $display("FAIL arb_gap0: got rr=%0b fp=%0b want 0/0", valid_rr, valid_fp); end
    checks++; if (pending_rr !== 8'h48) begin fails++; $display("FAIL rr_pending1: got %h want 48", pending_rr); end
    checks++; if (pending_fp !== 8'h0A) begin fails++; $display("FAIL fp_pending1: got %h want 0a", pending_fp); end
    tick();
    checks++; if (valid_rr !== 1'b1 || code_rr !== 3'd3) begin fails++; $display("FAIL rr_grant1: got valid=%0b code=%0d want 1/3", valid_rr, code_rr); end
    checks++; if (valid_fp !== 1'b1 || code_fp !== 3'd3) begin fails++; $display("FAIL fp_grant1: got valid=%0b code=%0d want 1/3", valid_fp, code_fp); end
    tick();
    checks++; if (valid_rr !== 1'b0 || valid_fp !== 1'b0) begin fails++; $display("FAIL arb_gap1: got rr=%0b fp=%0b want 0/0", valid_rr, valid_fp); end
    tick();
    checks++; if (valid_rr !== 1'b1 || code_rr !== 3'd6) begin fails++; $display("FAIL rr_grant2: got valid=%0b code=%0d want 1/6", valid_rr, code_rr); end
    checks++; if (valid_fp !== 1'b1 || code_fp !== 3'd1) begin fails++; $display("FAIL fp_grant2: got valid=%0b code=%0d want 1/1", valid_fp, code_fp); end
    tick();
    checks++; if (valid_rr !== 1'b0 || pending_rr !== 8'h00 || pending_fp !== 8'h00) begin fails++; $display("FAIL arb_done: got valid=%0b pend_rr=%h pend_fp=%h want 0/00/00", valid_rr, pending_rr, pending_fp); end
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    req   = 8'h04;
    tick();
    req = 8'h00;
    checks++; if (overflow_rr !== 1'b0) begin fails++; $display("FAIL ovf_first_rise: got %0b want 0", overflow_rr); end
    tick();
    checks++; if (valid_rr !== 1'b1 || code_rr !== 3'd2) begin fails++; $display("FAIL ovf_present: got valid=%0b code=%0d want 1/2", valid_rr, code_rr); end
    req = 8'h04;
    tick();
    checks++; if (overflow_rr !== 1'b1 || overflow_fp !== 1'b1) begin fails++; $display("FAIL ovf_pulse: got rr=%0b fp=%0b want 1/1", overflow_rr, overflow_fp); end
    checks++; if (valid_rr !== 1'b1 || code_rr !== 3'd2 || pending_rr !== 8'h04) begin fails++; $display("FAIL ovf_stable: got valid=%0b code=%0d pending=%h want 1/2/04", valid_rr, code_rr, pending_rr); end
    req = 8'h00;
    tick();
    checks++; if (overflow_rr !== 1'b0) begin fails++; $display("FAIL ovf_one_cycle: got %0b want 0", overflow_rr); end
    ready = 1'b1;
    tick();
    checks++; if (valid_rr !== 1'b0 || pending_rr !== 8'h00) begin fails++; $display("FAIL ovf_accept: got valid=%0b pending=%h want 0/00", valid_rr, pending_rr); end
    tick();
    checks++; if (valid_rr !== 1'b0 || valid_fp !== 1'b0) begin fails++; $display("FAIL ovf_single_grant: got rr=%0b fp=%0b want 0/0", valid_rr, valid_fp); end
  endtask

  task automatic test_coincident();
    ready = 1'b0;
    req   = 8'h10;
    tick();
    req = 8'h00;
    tick();
    checks++; if (valid_rr !== 1'b1 || code_rr !== 3'd4) begin fails++; $display("FAIL coin_present: got valid=%0b code=%0d want 1/4", valid_rr, code_rr); end
    ready = 1'b1;
    req   = 8'h10;
    tick();
    req = 8'h00;
    checks++; if (overflow_rr !== 1'b0 || overflow_fp !== 1'b0) begin fails++; $display("FAIL coin_no_overflow: got rr=%0b fp=%0b want 0/0", overflow_rr, overflow_fp); end
    checks++; if (valid_rr !== 1'b0 || pending_rr !== 8'h10) begin fails++; $display("FAIL coin_retained: got valid=%0b pending=%h want 0/10", valid_rr, pending_rr); end
    tick();
    checks++; if (valid_rr !== 1'b1 || code_rr !== 3'd4) begin fails++; $display("FAIL coin_regrant: got valid=%0b code=%0d want 1/4", valid_rr, code_rr); end
    tick();
    checks++; if (valid_rr !== 1'b0 || pending_rr !== 8'h00) begin fails++; $display("FAIL coin_done: got valid=%0b pending=%h want 0/00", valid_rr, pending_rr); end
  endtask

  task automatic test_reset_mid_present();
    ready = 1'b0;
    req   = 8'h01;
    tick();
    tick();
    checks++; if (valid_rr !== 1'b1 || code_rr !== 3'd0) begin fails++; $display("FAIL rst_mid_present: got valid=%0b code=%0d want 1/0", valid_rr, code_rr); end
    rst_n = 1'b0;
    #1;
    checks++; if (valid_rr !== 1'b0 || pending_rr !== 8'h00) begin fails++; $display("FAIL rst_mid_immediate: got valid=%0b pending=%h want 0/00", valid_rr, pending_rr); end
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (valid_rr !== 1'b0 || pending_rr !== 8'h00) begin fails++; $display("FAIL rst_held_high: got valid=%0b pending=%h want 0/00", valid_rr, pending_rr); end
    req = 8'h00;
    tick();
    checks++; if (pending_rr !== 8'h00) begin fails++; $display("FAIL rst_fall: got %h want 00", pending_rr); end
    req = 8'h01;
    tick();
    checks++; if (pending_rr !== 8'h01) begin fails++; $display("FAIL rst_rerise: got %h want 01", pending_rr); end
    tick();
    checks++; if (valid_rr !== 1'b1 || code_rr !== 3'd0) begin fails++; $display("FAIL rst_regrant: got valid=%0b code=%0d want 1/0", valid_rr, code_rr); end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    ready = 1'b0;
    test_reset();
    test_single();
    test_arbitration();
    test_overflow();
    test_coincident();
    test_reset_mid_present();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
